branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 14 +
 rtl/branch_predictor_sat_counter.sv | 19 +
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared configuration for the branch predictor: default datapath width and
// the 2-bit saturating counter encodings.
package branch_predictor_pkg;

    localparam int unsigned BP_XLEN = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i && (ctr_i != CTR_ST)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!taken_i && (ctr_i != CTR_SNT)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational
// fetch-time lookup, EX-stage update, misprediction detection and counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN     = BP_XLEN,
    parameter int unsigned IDX_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_take_branch,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     ctrl_count,
    output logic [31:0]     mispred_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_W   = XLEN - IDX_BITS - 2;

    logic              valid_q   [ENTRIES];
    logic              is_jump_q [ENTRIES];
    logic [1:0]        ctr_q     [ENTRIES];
    logic [TAG_W-1:0]  tag_q     [ENTRIES];
    logic [XLEN-1:0]   target_q  [ENTRIES];

    logic [31:0]       ctrl_cnt_q, ctrl_cnt_d;
    logic [31:0]       mis_cnt_q, mis_cnt_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0]    if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                upd_ev, act_taken;
    logic                wr_entry_d, wr_ctr_d;
    logic [1:0]          ctr_step, ctr_d;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup reads the registered table, so a same-cycle update is
    // only visible from the following cycle.
    assign if_idx      = if_pc[IDX_BITS+1:2];
    assign if_tag      = if_pc[XLEN-1:IDX_BITS+2];
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && (is_jump_q[if_idx] || ctr_q[if_idx][1]);
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);

    assign ex_idx    = ex_pc[IDX_BITS+1:2];
    assign ex_tag    = ex_pc[XLEN-1:IDX_BITS+2];
    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd_ev    = ex_valid && (ex_branch || ex_jump);
    assign act_taken = ex_jump || ex_take_branch;

    bp_sat_counter u_ctr (
        .ctr_i   (ctr_q[ex_idx]),
        .taken_i (act_taken),
        .ctr_o   (ctr_step)
    );

    assign mispredict  = upd_ev && ((act_taken != ex_pred_taken) ||
                                    (act_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = act_taken ? ex_target : ex_pc + XLEN'(4);

    always_comb begin
        wr_entry_d = upd_ev && act_taken;
        wr_ctr_d   = upd_ev && (act_taken || ex_hit);
        ctr_d      = ctr_step;
        if (ex_jump) begin
            ctr_d = CTR_ST;
        end else if (act_taken && !ex_hit) begin
            ctr_d = CTR_WT;
        end
        ctrl_cnt_d = ctrl_cnt_q;
        if (upd_ev && (ctrl_cnt_q != '1)) begin
            ctrl_cnt_d = ctrl_cnt_q + 32'd1;
        end
        mis_cnt_d = mis_cnt_q;
        if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]   <= 1'b0;
                is_jump_q[i] <= 1'b0;
                ctr_q[i]     <= CTR_WNT;
            end
            ctrl_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            if (wr_entry_d) begin
                valid_q[ex_idx]   <= 1'b1;
                is_jump_q[ex_idx] <= ex_jump;
            end
            if (wr_ctr_d) begin
                ctr_q[ex_idx] <= ctr_d;
            end
            ctrl_cnt_q <= ctrl_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_entry_d) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_target;
        end
    end

    assign ctrl_count    = ctrl_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_take_branch;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] ctrl_count;
    logic [31:0] mispred_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    branch_predictor #(.XLEN(32), .IDX_BITS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_branch      (ex_branch),
        .ex_jump        (ex_jump),
        .ex_take_branch (ex_take_branch),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .ctrl_count     (ctrl_count),
        .mispred_count  (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] tgt, input logic br,
                          input logic jmp, input logic tk, input logic ptk,
                          input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_branch      = br;
        ex_jump        = jmp;
        ex_take_branch = tk;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
        ex_jump   = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, tk});
        check({tag, "_target"}, {32'd0, pred_target}, {32'd0, tgt});
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 32'h100;
        ex_valid = 1'b0; ex_pc = '0; ex_target = '0; ex_branch = 1'b0; ex_jump = 1'b0;
        ex_take_branch = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = '0;

        // Reset state, during and after reset
        #2;
        check("rst_during_taken", {63'd0, pred_taken}, 64'd0);
        check("rst_during_target", {32'd0, pred_target}, 64'h104);
        do_reset();
        look("rst", 32'h100, 1'b0, 32'h104);
        check("rst_ctrl", {32'd0, ctrl_count}, 64'd0);
        check("rst_mis", {32'd0, mispred_count}, 64'd0);

        // Taken BEQ at 0x100 -> 0x80, predicted not-taken
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
        check("beq_mis", {63'd0, mispredict}, 64'd1);
        check("beq_redirect", {32'd0, redirect_pc}, 64'h80);
        tick();
        look("beq_after", 32'h100, 1'b1, 32'h80);

        // Counter walk: 10 -> 11 -> 11 -> NT 10 -> NT 01 -> NT 00 -> NT 00 -> T 01 -> T 10
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
        check("t2_nomis", {63'd0, mispredict}, 64'd0);
        tick();
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
        tick();
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        check("nt1_mis", {63'd0, mispredict}, 64'd1);
        check("nt1_redirect", {32'd0, redirect_pc}, 64'h104);
        tick();
        look("ctr10", 32'h100, 1'b1, 32'h80);
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
        tick();
        look("ctr01", 32'h100, 1'b0, 32'h104);
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        check("nt3_nomis", {63'd0, mispredict}, 64'd0);
        tick();
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 32'h104);
        tick();
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
        tick();
        look("ctr01_from00", 32'h100, 1'b0, 32'h104);
        set_ex(32'h100, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104);
        tick();
        look("ctr10_again", 32'h100, 1'b1, 32'h80);

        // Non-events must not update anything
        set_ex(32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104);
        check("noev_mis", {63'd0, mispredict}, 64'd0);
        tick();
        ex_branch = 1'b1; ex_take_branch = 1'b0; ex_pc = 32'h100; #1;
        check("invalid_mis", {63'd0, mispredict}, 64'd0);
        tick();
        check("walk_ctrl", {32'd0, ctrl_count}, 64'd9);
        check("walk_mis", {32'd0, mispred_count}, 64'd5);
        look("noev_keep", 32'h100, 1'b1, 32'h80);

        // JAL at 0x200 then aliasing branch at 0x240 overwrites the entry
        do_reset();
        set_ex(32'h200, 32'h400, 1'b0, 1'b1, 1'b0, 1'b0, 32'h204);
        check("jal_mis", {63'd0, mispredict}, 64'd1);
        check("jal_redirect", {32'd0, redirect_pc}, 64'h400);
        tick();
        look("jal_hit", 32'h200, 1'b1, 32'h400);
        set_ex(32'h240, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0, 32'h244);
        tick();
        look("alias_old", 32'h200, 1'b0, 32'h204);
        look("alias_new", 32'h240, 1'b1, 32'h500);
        set_ex(32'h300, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0, 32'h304);
        check("ntmiss_nomis", {63'd0, mispredict}, 64'd0);
        tick();
        look("ntmiss_noalloc", 32'h300, 1'b0, 32'h304);
        look("ntmiss_keep", 32'h240, 1'b1, 32'h500);

        // Same-cycle update and lookup on index 0
        do_reset();
        if_pc = 32'h0;
        set_ex(32'h0, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4);
        check("bypass_old_taken", {63'd0, pred_taken}, 64'd0);
        check("bypass_old_target", {32'd0, pred_target}, 64'h4);
        tick();
        look("bypass_new", 32'h0, 1'b1, 32'h40);

        // JALR predicted to 0x300, actual 0x340
        do_reset();
        set_ex(32'h10, 32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 32'h14);
        tick();
        look("jalr_hit", 32'h10, 1'b1, 32'h300);
        check("jalr_mis_before", {32'd0, mispred_count}, 64'd1);
        set_ex(32'h10, 32'h340, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300);
        check("jalr_mis", {63'd0, mispredict}, 64'd1);
        check("jalr_redirect", {32'd0, redirect_pc}, 64'h340);
        tick();
        check("jalr_mis_after", {32'd0, mispred_count}, 64'd2);
        check("jalr_ctrl", {32'd0, ctrl_count}, 64'd2);
        look("jalr_retarget", 32'h10, 1'b1, 32'h340);

        // Reset asserted while an update is pending discards it
        do_reset();
        set_ex(32'h20, 32'h60, 1'b1, 1'b0, 1'b1, 1'b0, 32'h24);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ex_valid = 1'b0;
        #1;
        look("rst_mid", 32'h20, 1'b0, 32'h24);
        check("rst_mid_ctrl", {32'd0, ctrl_count}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
